// File: rtl/seg7_scan_driver_if.sv
// Bus between the 7-segment scan driver and its digit multiplexer / display pins.
// The master side drives ENABLE and DIGIT_IN; the slave (driver) returns select, anodes and segments.
interface seg7_scan_driver_if;
   logic       ENABLE;
   logic [4:0] DIGIT_IN;
   logic [1:0] DIGIT_SEL_OUT;
   logic [3:0] SEG_SELECT_OUT;
   logic [7:0] HEX_OUT;

   modport master (
      output ENABLE,
      output DIGIT_IN,
      input  DIGIT_SEL_OUT,
      input  SEG_SELECT_OUT,
      input  HEX_OUT
   );

   modport slave (
      input  ENABLE,
      input  DIGIT_IN,
      output DIGIT_SEL_OUT,
      output SEG_SELECT_OUT,
      output HEX_OUT
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment scan driver with registered, active-low anode/segment outputs.
// Defining SEG7_GHOST_BLANK_EN adds BLANK_CYCLES of anode-off time at the start of each digit slot.
module seg7_scan_driver #(
   parameter int unsigned SCAN_DIV     = 100000,
   parameter int unsigned BLANK_CYCLES = 1000
) (
   input  logic              CLK,
   input  logic              RESET,
   seg7_scan_driver_if.slave bus
);
   localparam int unsigned     CW   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0]   LAST = CW'(SCAN_DIV - 1);

   localparam logic [0:0] ST_SCAN  = 1'b0;
   localparam logic [0:0] ST_BLANK = 1'b1;

`ifdef SEG7_GHOST_BLANK_EN
   localparam bit            HAS_BLANK  = (BLANK_CYCLES > 0);
   localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
`endif

   logic [CW-1:0] cnt;
   logic [1:0]    sel;
   logic [0:0]    state;
   logic [0:0]    state_nxt;
   logic [3:0]    seg;
   logic [7:0]    hex;
   logic          tick;
   logic [6:0]    dec;
   logic [3:0]    anode;

   always_comb begin
      tick = bus.ENABLE && (cnt == LAST);
   end

   always_comb begin
      anode = ~(4'b0001 << sel);
   end

   // Segment patterns, gfedcba, active low.
   always_comb begin
      dec = 7'h7F;
      case (bus.DIGIT_IN[3:0])
         4'h0: dec = 7'h40;
         4'h1: dec = 7'h79;
         4'h2: dec = 7'h24;
         4'h3: dec = 7'h30;
         4'h4: dec = 7'h19;
         4'h5: dec = 7'h12;
         4'h6: dec = 7'h02;
         4'h7: dec = 7'h78;
         4'h8: dec = 7'h00;
         4'h9: dec = 7'h10;
         4'hA: dec = 7'h08;
         4'hB: dec = 7'h03;
         4'hC: dec = 7'h46;
         4'hD: dec = 7'h21;
         4'hE: dec = 7'h06;
         4'hF: dec = 7'h0E;
         default: dec = 7'h7F;
      endcase
   end

   always_comb begin
      state_nxt = state;
`ifdef SEG7_GHOST_BLANK_EN
      if (bus.ENABLE) begin
         if (state == ST_SCAN && tick && HAS_BLANK) begin
            state_nxt = ST_BLANK;
         end else if (state == ST_BLANK && cnt == BLANK_LAST) begin
            state_nxt = ST_SCAN;
         end
      end
`else
      state_nxt = ST_SCAN;
`endif
   end

   // Anodes follow the next state so the blank window lines up with the slot's first
   // prescaler counts; in SCAN they show the digit selected during the sampled cycle.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         cnt   <= '0;
         sel   <= '0;
         state <= ST_SCAN;
         seg   <= '1;
         hex   <= '1;
      end else begin
         hex   <= {~bus.DIGIT_IN[4], dec};
         state <= state_nxt;
         if (bus.ENABLE) begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) begin
               sel <= sel + 2'd1;
            end
            seg <= (state_nxt == ST_BLANK) ? '1 : anode;
         end else begin
            seg <= '1;
         end
      end
   end

   assign bus.DIGIT_SEL_OUT  = sel;
   assign bus.SEG_SELECT_OUT = seg;
   assign bus.HEX_OUT        = hex;

   param_ok: assert property (@(posedge CLK) (SCAN_DIV >= 2) && (BLANK_CYCLES < SCAN_DIV));

   anode_onehot: assert property (@(posedge CLK) disable iff (RESET)
      $onehot0(~bus.SEG_SELECT_OUT));
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized self-checking bench for seg7_scan_driver; expected outputs come from a slot-position model.
// Build with SEG7_GHOST_BLANK_EN defined to check the blanking variant.
module tb_seg7_scan_driver;
   localparam int unsigned SD = 4;
   localparam int unsigned BC = 1;
`ifdef SEG7_GHOST_BLANK_EN
   localparam bit GHOST = 1'b1;
`else
   localparam bit GHOST = 1'b0;
`endif

   logic CLK   = 1'b0;
   logic RESET = 1'b1;

   seg7_scan_driver_if bus ();

   seg7_scan_driver #(
      .SCAN_DIV     (SD),
      .BLANK_CYCLES (BC)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   // Digit multiplexer: a table indexed by the DUT's select, or a forced value.
   logic [4:0] tbl [4];
   logic       force_mode = 1'b1;
   logic [4:0] force_val  = '0;
   assign bus.DIGIT_IN = force_mode ? force_val : tbl[bus.DIGIT_SEL_OUT];

   logic [6:0] dec_tbl   [16];
   logic [3:0] anode_tbl [4];

   int unsigned pos;
   int          checks = 0;
   int          errors = 0;
   logic [3:0]  exp_seg;
   logic [7:0]  exp_hex;
   logic [1:0]  exp_sel;

   // pos = number of enabled scan cycles since reset; slot = pos / SD, digit = slot mod 4.
   function automatic void model_edge();
      int unsigned p;
      logic [1:0]  dg;
      logic [4:0]  din;
      dg  = 2'((pos / SD) % 4);
      din = force_mode ? force_val : tbl[dg];
      if (RESET) begin
         pos     = 0;
         exp_seg = 4'hF;
         exp_hex = 8'hFF;
      end else begin
         exp_hex = {~din[4], dec_tbl[din[3:0]]};
         if (bus.ENABLE) begin
            p       = pos + 1;
            exp_seg = (GHOST && p >= SD && (p % SD) < BC) ? 4'hF : anode_tbl[dg];
            pos     = p;
         end else begin
            exp_seg = 4'hF;
         end
      end
      exp_sel = 2'((pos / SD) % 4);
   endfunction

   task automatic cyc();
      model_edge();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RESET      = 1'b1;
      bus.ENABLE = 1'($urandom_range(0, 1));
      for (int i = 0; i < 2; i++) begin
         cyc();
         if ({bus.SEG_SELECT_OUT, bus.HEX_OUT, bus.DIGIT_SEL_OUT} !== {exp_seg, exp_hex, exp_sel}) begin
            errors++;
            $display("FAIL reset: seg/hex/sel got %b/%h/%0d expected %b/%h/%0d",
                     bus.SEG_SELECT_OUT, bus.HEX_OUT, bus.DIGIT_SEL_OUT, exp_seg, exp_hex, exp_sel);
         end
         checks++;
      end
   endtask

   task automatic test_scan();
      force_mode = 1'b0;
      tbl[0] = 5'h01; tbl[1] = 5'h1A; tbl[2] = 5'h0F; tbl[3] = 5'h08;
      RESET = 1'b1;
      cyc();
      RESET      = 1'b0;
      bus.ENABLE = 1'b1;
      cyc();
      if (bus.SEG_SELECT_OUT !== 4'hE || bus.HEX_OUT !== 8'hF9) begin
         errors++;
         $display("FAIL first_slot: seg/hex got %b/%h expected 1110/f9", bus.SEG_SELECT_OUT, bus.HEX_OUT);
      end
      checks++;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if ({bus.SEG_SELECT_OUT, bus.HEX_OUT, bus.DIGIT_SEL_OUT} !== {exp_seg, exp_hex, exp_sel}) begin
            errors++;
            $display("FAIL scan cyc %0d: seg/hex/sel got %b/%h/%0d expected %b/%h/%0d", i,
                     bus.SEG_SELECT_OUT, bus.HEX_OUT, bus.DIGIT_SEL_OUT, exp_seg, exp_hex, exp_sel);
         end
         checks++;
      end
   endtask

   task automatic test_enable_gate();
      RESET = 1'b1;
      cyc();
      RESET      = 1'b0;
      bus.ENABLE = 1'b1;
      for (int i = 0; i < 64 && !((pos / SD) % 4 == 2 && pos % SD == 1); i++) cyc();
      if (!((pos / SD) % 4 == 2 && pos % SD == 1)) begin
         errors++;
         $display("FAIL gate_reach: model pos got %0d expected digit 2 mid-slot", pos);
      end
      checks++;
      bus.ENABLE = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if ({bus.SEG_SELECT_OUT, bus.HEX_OUT, bus.DIGIT_SEL_OUT} !== {exp_seg, exp_hex, exp_sel}) begin
            errors++;
            $display("FAIL gate_off cyc %0d: seg/hex/sel got %b/%h/%0d expected %b/%h/%0d", i,
                     bus.SEG_SELECT_OUT, bus.HEX_OUT, bus.DIGIT_SEL_OUT, exp_seg, exp_hex, exp_sel);
         end
         checks++;
      end
      bus.ENABLE = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if ({bus.SEG_SELECT_OUT, bus.HEX_OUT, bus.DIGIT_SEL_OUT} !== {exp_seg, exp_hex, exp_sel}) begin
            errors++;
            $display("FAIL gate_resume cyc %0d: seg/hex/sel got %b/%h/%0d expected %b/%h/%0d", i,
                     bus.SEG_SELECT_OUT, bus.HEX_OUT, bus.DIGIT_SEL_OUT, exp_seg, exp_hex, exp_sel);
         end
         checks++;
      end
   endtask

   task automatic test_tick_suppress();
      RESET = 1'b1;
      cyc();
      RESET      = 1'b0;
      bus.ENABLE = 1'b1;
      for (int i = 0; i < int'(SD) - 1; i++) cyc();
      bus.ENABLE = 1'b0;
      cyc();
      if (bus.DIGIT_SEL_OUT !== exp_sel || bus.SEG_SELECT_OUT !== 4'hF) begin
         errors++;
         $display("FAIL tick_suppress: sel/seg got %0d/%b expected %0d/1111",
                  bus.DIGIT_SEL_OUT, bus.SEG_SELECT_OUT, exp_sel);
      end
      checks++;
      bus.ENABLE = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc();
         if ({bus.SEG_SELECT_OUT, bus.HEX_OUT, bus.DIGIT_SEL_OUT} !== {exp_seg, exp_hex, exp_sel}) begin
            errors++;
            $display("FAIL tick_resume cyc %0d: seg/hex/sel got %b/%h/%0d expected %b/%h/%0d", i,
                     bus.SEG_SELECT_OUT, bus.HEX_OUT, bus.DIGIT_SEL_OUT, exp_seg, exp_hex, exp_sel);
         end
         checks++;
      end
   endtask

   task automatic test_reset_mid();
      RESET = 1'b1;
      cyc();
      RESET      = 1'b0;
      bus.ENABLE = 1'b1;
      for (int i = 0; i < 64 && !((pos / SD) % 4 == 3 && pos % SD == 2); i++) cyc();
      RESET = 1'b1;
      cyc();
      if (bus.SEG_SELECT_OUT !== 4'hF || bus.HEX_OUT !== 8'hFF || bus.DIGIT_SEL_OUT !== 2'd0) begin
         errors++;
         $display("FAIL reset_mid: seg/hex/sel got %b/%h/%0d expected 1111/ff/0",
                  bus.SEG_SELECT_OUT, bus.HEX_OUT, bus.DIGIT_SEL_OUT);
      end
      checks++;
      RESET = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         if ({bus.SEG_SELECT_OUT, bus.HEX_OUT, bus.DIGIT_SEL_OUT} !== {exp_seg, exp_hex, exp_sel}) begin
            errors++;
            $display("FAIL reset_restart cyc %0d: seg/hex/sel got %b/%h/%0d expected %b/%h/%0d", i,
                     bus.SEG_SELECT_OUT, bus.HEX_OUT, bus.DIGIT_SEL_OUT, exp_seg, exp_hex, exp_sel);
         end
         checks++;
      end
   endtask

   task automatic test_decode();
      RESET = 1'b1;
      cyc();
      RESET      = 1'b0;
      bus.ENABLE = 1'b0;
      force_mode = 1'b1;
      for (int v = 0; v < 32; v++) begin
         force_val = 5'(v);
         cyc();
         if (bus.HEX_OUT !== exp_hex || bus.SEG_SELECT_OUT !== 4'hF) begin
            errors++;
            $display("FAIL decode %02h: hex/seg got %h/%b expected %h/1111",
                     v, bus.HEX_OUT, bus.SEG_SELECT_OUT, exp_hex);
         end
         checks++;
      end
      force_mode = 1'b0;
   endtask

   task automatic test_random();
      force_mode = 1'b0;
      for (int k = 0; k < 4; k++) tbl[k] = 5'($urandom_range(0, 31));
      RESET = 1'b1;
      cyc();
      for (int i = 0; i < 300; i++) begin
         RESET      = ($urandom_range(0, 39) == 0);
         bus.ENABLE = ($urandom_range(0, 4) != 0);
         if (i % 100 == 50) tbl[$urandom_range(0, 3)] = 5'($urandom_range(0, 31));
         cyc();
         if ({bus.SEG_SELECT_OUT, bus.HEX_OUT, bus.DIGIT_SEL_OUT} !== {exp_seg, exp_hex, exp_sel}) begin
            errors++;
            $display("FAIL random cyc %0d: seg/hex/sel got %b/%h/%0d expected %b/%h/%0d", i,
                     bus.SEG_SELECT_OUT, bus.HEX_OUT, bus.DIGIT_SEL_OUT, exp_seg, exp_hex, exp_sel);
         end
         checks++;
      end
   endtask

   initial begin
      dec_tbl[0]  = 7'h40; dec_tbl[1]  = 7'h79; dec_tbl[2]  = 7'h24; dec_tbl[3]  = 7'h30;
      dec_tbl[4]  = 7'h19; dec_tbl[5]  = 7'h12; dec_tbl[6]  = 7'h02; dec_tbl[7]  = 7'h78;
      dec_tbl[8]  = 7'h00; dec_tbl[9]  = 7'h10; dec_tbl[10] = 7'h08; dec_tbl[11] = 7'h03;
      dec_tbl[12] = 7'h46; dec_tbl[13] = 7'h21; dec_tbl[14] = 7'h06; dec_tbl[15] = 7'h0E;
      anode_tbl[0] = 4'b1110; anode_tbl[1] = 4'b1101;
      anode_tbl[2] = 4'b1011; anode_tbl[3] = 4'b0111;
      for (int k = 0; k < 4; k++) tbl[k] = '0;
      pos        = 0;
      bus.ENABLE = 1'b0;
      #1;
      test_reset();
      test_scan();
      test_enable_gate();
      test_tick_suppress();
      test_reset_mid();
      test_decode();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
